// File: rtl/time_display.sv
// Binary hh:mm to BCD converter (repeated subtraction) driving a 4-digit
// multiplexed seven-segment display. Optional colon blink: COLON_BLINK_EN.
module time_display #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_hours_left,
  output logic [3:0] o_hours_right,
  output logic [2:0] o_minutes_left,
  output logic [3:0] o_minutes_right,
  output logic [3:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_colon,
  output logic [1:0] dbg_state
);

  // Request handshake: i_start is honoured only in IDLE; o_busy is high in
  // CONV_H/CONV_M, o_done (with o_err on bad input) pulses for the DONE cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_H = 2'd1,
    CONV_M = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [4:0] rem_h;
  logic [5:0] rem_m;
  logic [1:0] tens_h;
  logic [2:0] tens_m;
  logic       err_flag;

  logic [15:0] scan_cnt;
  logic        scan_wrap;
  logic [1:0]  idx, idx_nx;
  logic [3:0]  sel_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;
    dbg_state = state;
    case (state)
      IDLE: begin
        if (i_start) state_nx = CONV_H;
      end
      CONV_H: begin
        o_busy = 1'b1;
        // An out-of-range sample spends one cycle here and skips conversion.
        if (err_flag)               state_nx = DONE;
        else if (rem_h < 5'd10)     state_nx = CONV_M;
      end
      CONV_M: begin
        o_busy = 1'b1;
        if (rem_m < 6'd10) state_nx = DONE;
      end
      DONE: begin
        o_done   = 1'b1;
        o_err    = err_flag;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_h           <= '0;
      rem_m           <= '0;
      tens_h          <= '0;
      tens_m          <= '0;
      err_flag        <= 1'b0;
      o_hours_left    <= '0;
      o_hours_right   <= '0;
      o_minutes_left  <= '0;
      o_minutes_right <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            rem_h    <= i_hours;
            rem_m    <= i_minutes;
            tens_h   <= '0;
            tens_m   <= '0;
            err_flag <= (i_hours > 5'd23) || (i_minutes > 6'd59);
          end
        end
        CONV_H: begin
          if (!err_flag && rem_h >= 5'd10) begin
            rem_h  <= rem_h - 5'd10;
            tens_h <= tens_h + 2'd1;
          end
        end
        CONV_M: begin
          if (rem_m >= 6'd10) begin
            rem_m  <= rem_m - 6'd10;
            tens_m <= tens_m + 3'd1;
          end else begin
            // All four digits land together on entry to DONE.
            o_hours_left    <= tens_h;
            o_hours_right   <= rem_h[3:0];
            o_minutes_left  <= tens_m;
            o_minutes_right <= rem_m[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign scan_wrap = (scan_cnt == 16'(SCAN_DIV - 1));
  assign idx_nx    = scan_wrap ? idx + 2'd1 : idx;

  always_comb begin
    sel_digit = '0;
    case (idx_nx)
      2'd0: sel_digit = o_minutes_right;
      2'd1: sel_digit = {1'b0, o_minutes_left};
      2'd2: sel_digit = o_hours_right;
      2'd3: sel_digit = {2'b00, o_hours_left};
      default: sel_digit = '0;
    endcase
  end

  // Anode and segments are registered from the same next index, so they
  // always switch together and never show a blank or mixed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      o_an     <= 4'b1110;
      o_seg    <= 7'b1000000;
    end else begin
      scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      idx      <= idx_nx;
      o_an     <= ~(4'b0001 << idx_nx);
      o_seg    <= seg_decode(sel_digit);
    end
  end

`ifdef COLON_BLINK_EN
  logic [31:0] blink_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      o_colon   <= 1'b1;
    end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      o_colon   <= ~o_colon;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end
`else
  // Colon held on; BLINK_DIV is referenced only to keep it a used parameter.
  assign o_colon = 1'b1 | (BLINK_DIV < 0);
`endif

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: conversions checked through an expected
// queue on o_done, plus reset, scan, colon and abort checks.
module tb_time_display;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] i_hours = '0;
  logic [5:0] i_minutes = '0;
  logic       i_start = 1'b0;
  logic       o_busy, o_done, o_err, o_colon;
  logic [1:0] o_hours_left, dbg_state;
  logic [3:0] o_hours_right, o_minutes_right, o_an;
  logic [2:0] o_minutes_left;
  logic [6:0] o_seg;

  always #5 clk = ~clk;

  time_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .i_hours(i_hours), .i_minutes(i_minutes),
    .i_start(i_start), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_hours_left(o_hours_left), .o_hours_right(o_hours_right),
    .o_minutes_left(o_minutes_left), .o_minutes_right(o_minutes_right),
    .o_an(o_an), .o_seg(o_seg), .o_colon(o_colon), .dbg_state(dbg_state)
  );

  // Entry: {latency[7:0], err, hl[1:0], hr[3:0], ml[2:0], mr[3:0]}
  logic [21:0] exp_q[$];
  logic [12:0] shown = '0;
  int n_checks = 0;
  int n_fail = 0;
  int k_ticks = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) k_ticks++;
    #1;
  endtask

  function automatic logic [3:0] digit_of(input int i);
    case (i)
      0: return shown[3:0];
      1: return {1'b0, shown[6:4]};
      2: return shown[10:7];
      default: return {2'b00, shown[12:11]};
    endcase
  endfunction

  task automatic push_expected(input int h, input int m);
    if (h > 23 || m > 59) begin
      exp_q.push_back({8'd2, 1'b1, shown});
    end else begin
      shown = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
      exp_q.push_back({8'(3 + h / 10 + m / 10), 1'b0, shown});
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"}, o_busy, 1'b0);
    check({pfx, "_done"}, o_done, 1'b0);
    check({pfx, "_err"}, o_err, 1'b0);
    check({pfx, "_digits"}, {o_hours_left, o_hours_right, o_minutes_left, o_minutes_right}, 13'd0);
    check({pfx, "_an"}, o_an, 4'b1110);
    check({pfx, "_seg"}, o_seg, 7'b1000000);
    check({pfx, "_colon"}, o_colon, 1'b1);
    check({pfx, "_state"}, dbg_state, 2'd0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (o_done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  task automatic start_conv(input int h, input int m, input bit restart);
    logic [21:0] e;
    int lat;
    i_hours = 5'(h);
    i_minutes = 6'(m);
    i_start = 1'b1;
    push_expected(h, m);
    tick();
    check("busy_after_start", o_busy, 1'b1);
    lat = 1;
    if (restart) begin
      i_hours = 5'd0;
      i_minutes = 6'd0;
      tick();
      lat++;
    end
    i_start = 1'b0;
    i_hours = 5'($urandom_range(0, 31));
    i_minutes = 6'($urandom_range(0, 63));
    while (!o_done && lat < 40) begin
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    check("done_seen", o_done, 1'b1);
    check("latency", lat, e[21:14]);
    check("err", o_err, e[13]);
    check("digits", {o_hours_left, o_hours_right, o_minutes_left, o_minutes_right}, e[12:0]);
    check("busy_in_done", o_busy, 1'b0);
    tick();
    check("done_one_cycle", o_done, 1'b0);
  endtask

  initial begin
    logic [3:0] an_exp;
    int idx;
    repeat (3) tick();
    check_reset_values("reset");

    rst = 1'b1;
    start_conv(23, 59, 1'b0);
    start_conv(24, 0, 1'b0);
    start_conv(12, 34, 1'b1);
    count_done("no_extra_done", 12);

    for (int i = 0; i < 16; i++) begin
      tick();
      idx = (k_ticks / SCAN_DIV) % 4;
      an_exp = ~(4'b0001 << idx);
      check("scan_an", o_an, an_exp);
      check("scan_seg", o_seg, seg_tab[digit_of(idx)]);
`ifdef COLON_BLINK_EN
      check("colon", o_colon, 1'b1 ^ 1'((k_ticks / BLINK_DIV) % 2));
`else
      check("colon", o_colon, 1'b1);
`endif
    end

    start_conv(0, 0, 1'b0);
    start_conv(7, 5, 1'b0);
    start_conv(10, 60, 1'b0);
    start_conv(31, 63, 1'b0);

    i_hours = 5'd23;
    i_minutes = 6'd59;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    check("abort_in_conv_m", dbg_state, 2'd2);
    rst = 1'b0;
    k_ticks = 0;
    shown = '0;
    #1;
    check_reset_values("abort");
    repeat (2) tick();
    rst = 1'b1;
    count_done("no_done_after_abort", 12);
    start_conv(5, 9, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each display digit is driven; legal range 2..65535.
REQ-002 Parameter BLINK_DIV, default 50000000: clk cycles per colon toggle; used only with COLON_BLINK_EN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_hours  input  5  binary hours, legal 0..23.
REQ-006 i_minutes  input  6  binary minutes, legal 0..59.
REQ-007 i_start  input  1  one-cycle conversion request.
REQ-008 o_busy  output  1  high while a conversion is in progress.
REQ-009 o_done  output  1  one-cycle pulse at the end of every accepted conversion.
REQ-010 o_err  output  1  one-cycle pulse, coincident with o_done, when the sampled input is out of range.
REQ-011 o_hours_left / o_hours_right / o_minutes_left / o_minutes_right  output  2/4/3/4  BCD digits of the last valid time.
REQ-012 o_an  output  4  active-low one-hot digit enable; bit 3 = hours_left ... bit 0 = minutes_right.
REQ-013 o_seg  output  7  active-low segments, bit 6..0 = g..a.
REQ-014 o_colon  output  1  colon segment, active-high.

Function
REQ-015 FSM states: IDLE, CONV_H, CONV_M, DONE; from reset the FSM is in IDLE.
REQ-016 IDLE: i_start=1 registers i_hours/i_minutes into working remainders, clears tens counters, enters CONV_H; o_busy=1 from the next cycle.
REQ-017 Range check at sampling: hours>23 or minutes>59 -> skip to DONE next cycle with o_err=1; digit outputs unchanged.
REQ-018 CONV_H: each cycle, remainder>=10 -> subtract 10 and increment hours tens; else go to CONV_M.
REQ-019 CONV_M: same rule on the minutes remainder; when remainder<10 go to DONE.
REQ-020 DONE (one cycle): o_done=1, o_busy=0, all four digit outputs updated together on entry (valid case only), then IDLE.
REQ-021 Latency from i_start to the o_done cycle = 1 + (tens_h+1) + (tens_m+1) cycles; 23:59 -> 10 cycles; 00:00 -> 3 cycles.
REQ-022 i_start while o_busy=1 or in DONE is ignored; no queuing.
REQ-023 Input changes after sampling do not affect the conversion in progress.
REQ-024 Scan counter counts 0..SCAN_DIV-1; on wrap the digit index advances 0->1->2->3->0 (index 0 = minutes_right).
REQ-025 o_an/o_seg are registered, with exactly one o_an bit low at all times; o_seg decodes the selected digit (0=1000000 ... 9=0010000); digit codes >9 show all segments off.
REQ-026 Digit updates in DONE appear on o_seg no later than the next scan edge; there is no blanking glitch.

Reset
REQ-027 rst low forces immediately: FSM IDLE, o_busy=0, o_done=0, o_err=0, all digits 0, scan counter 0, index 0, o_an=1110, o_seg=1000000, o_colon=1.
REQ-028 Reset mid-conversion aborts it; no o_done is generated for the aborted request.
REQ-029 After rst deasserts, the first i_start is accepted in the first clock cycle.

Configuration
REQ-030 Macro COLON_BLINK_EN defined: a BLINK_DIV counter toggles o_colon at each wrap (first toggle BLINK_DIV cycles after reset).
REQ-031 Macro COLON_BLINK_EN undefined: o_colon constant 1; no blink counter is synthesised.

Verification
REQ-032 Reset, then i_hours=23, i_minutes=59, i_start pulse -> o_done 10 cycles later; digits 2,3,5,9; o_err=0.
REQ-033 i_hours=24, i_minutes=0, i_start -> o_done+o_err 2 cycles later; digits keep their previous values.
REQ-034 i_start again on the cycle after an accepted start, hours=00:00 -> ignored; only one o_done pulse.
REQ-035 SCAN_DIV=4, digits 1,2,3,4 -> o_an sequence 1110,1101,1011,0111, each 4 cycles; o_seg = codes 4,3,2,1.
REQ-036 rst asserted in CONV_M -> all outputs at reset values the same cycle; no o_done pulse follows.
REQ-037 COLON_BLINK_EN with BLINK_DIV=8 -> o_colon toggles every 8 cycles; without the macro -> o_colon stays 1.
